preg_execute: RTL and testbench
===============================

Name: preg_execute

Overview:
Execute-to-Memory pipeline register for the 5-stage RV32I core. It sits directly downstream of the Decode/Execute register and captures the execute-stage ALU result, store data, destination register and surviving control signals for the memory stage. It supports stall (hold), flush (bubble insertion) and validity tracking. It also keeps saturating retire and bubble counters for pipeline-occupancy debug.

Parameters:
DATA_WIDTH, 32, datapath width for ALU result, store data and PC+4
CNT_WIDTH, 16, width of each performance counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, asynchronous assert, active-low
ALUResultE  input  DATA_WIDTH  ALU output from execute
WriteDataE  input  DATA_WIDTH  forwarded rs2 value for stores
PCPlus4E  input  DATA_WIDTH  PC+4 for JAL/JALR writeback
RdE  input  5  destination register index
Funct3E  input  3  load/store width code
RegWriteE  input  1  register-file write enable
ResultSrcE  input  2  writeback mux select (00 ALU, 01 mem, 10 PC+4)
MemWriteE  input  1  data-memory write enable
ValidE  input  1  execute slot holds a real instruction
StallM  input  1  hold current contents
FlushM  input  1  load a bubble
CountClear  input  1  synchronous clear of both counters
ALUResultM  output  DATA_WIDTH  registered ALUResultE
WriteDataM  output  DATA_WIDTH  registered WriteDataE
PCPlus4M  output  DATA_WIDTH  registered PCPlus4E
RdM  output  5  registered RdE
Funct3M  output  3  registered Funct3E
RegWriteM  output  1  gated registered RegWriteE
ResultSrcM  output  2  registered ResultSrcE
MemWriteM  output  1  gated registered MemWriteE
ValidM  output  1  memory slot holds a real instruction
InstrCount  output  CNT_WIDTH  valid instructions loaded
BubbleCount  output  CNT_WIDTH  bubbles loaded

Behaviour:
- Clocking/reset: one clock, clk; reset asynchronous active-low on rst_n. While rst_n=0, all outputs are 0, including both counters. Deassertion takes effect at the next rising edge.
- Per-edge update priority: reset > FlushM > StallM > load.
- Flush (FlushM=1, regardless of StallM):
  - All data, RdM, Funct3M and control outputs become 0.
  - ValidM becomes 0.
  - BubbleCount increments.
- Stall (StallM=1, FlushM=0):
  - All pipeline outputs hold their values.
  - Neither counter changes.
- Load (StallM=0, FlushM=0):
  - All fields capture their E inputs with one cycle latency.
  - ValidM <= ValidE.
  - RegWriteM <= RegWriteE & ValidE; MemWriteM <= MemWriteE & ValidE. An invalid slot never writes the register file or memory.
  - Data fields are loaded even when ValidE=0.
  - ValidE=1: InstrCount increments. ValidE=0: BubbleCount increments.
- RdE=0 with RegWriteE=1 passes through unchanged; x0 suppression is the register file's responsibility.
- Counters:
  - Saturate at all-ones and never wrap.
  - CountClear=1 zeroes both counters at the edge, overriding any increment in the same cycle.
  - CountClear does not affect pipeline fields.
- No combinational path from any input to any output.
- Reset mid-stall or mid-flush: reset wins immediately (asynchronous). The first edge after release behaves per the priority rules above.

Test Plan:
- Reset: hold rst_n=0 with all inputs driven to nonzero values -> every output reads 0; on release with no edge, outputs remain 0.
- Load: ALUResultE=0x0000_1234, RdE=5, RegWriteE=1, ResultSrcE=01, ValidE=1, StallM=0, FlushM=0 -> after one edge ALUResultM=0x1234, RdM=5, RegWriteM=1, ResultSrcM=01, ValidM=1, InstrCount=1.
- Stall: load the value above, then StallM=1 for 3 cycles with ALUResultE=0xDEAD_BEEF -> ALUResultM stays 0x1234 and counters are unchanged; on StallM=0, ALUResultM=0xDEADBEEF the following cycle.
- Flush wins over stall: StallM=1, FlushM=1 with MemWriteE=1, ValidE=1 -> MemWriteM=0, ValidM=0, ALUResultM=0, BubbleCount increments by 1.
- Invalid gating: ValidE=0, RegWriteE=1, MemWriteE=1, WriteDataE=0xA5A5_A5A5 -> RegWriteM=0, MemWriteM=0, WriteDataM=0xA5A5A5A5, BubbleCount+1.
- Saturation/clear: with CNT_WIDTH=4, load 20 valid instructions -> InstrCount=15; assert CountClear together with a valid load -> InstrCount=0 next cycle.

Source files
------------

// File: rtl/preg_execute_if.sv
// Execute-to-Memory pipeline bundle: execute-stage fields in, memory-stage fields out.
// The master modport drives the E side; the slave modport is the pipeline register.
interface preg_execute_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] ALUResultE;
    logic [DATA_WIDTH-1:0] WriteDataE;
    logic [DATA_WIDTH-1:0] PCPlus4E;
    logic [4:0]            RdE;
    logic [2:0]            Funct3E;
    logic                  RegWriteE;
    logic [1:0]            ResultSrcE;
    logic                  MemWriteE;
    logic                  ValidE;

    logic [DATA_WIDTH-1:0] ALUResultM;
    logic [DATA_WIDTH-1:0] WriteDataM;
    logic [DATA_WIDTH-1:0] PCPlus4M;
    logic [4:0]            RdM;
    logic [2:0]            Funct3M;
    logic                  RegWriteM;
    logic [1:0]            ResultSrcM;
    logic                  MemWriteM;
    logic                  ValidM;

    modport master (
        output ALUResultE, WriteDataE, PCPlus4E, RdE, Funct3E,
               RegWriteE, ResultSrcE, MemWriteE, ValidE,
        input  ALUResultM, WriteDataM, PCPlus4M, RdM, Funct3M,
               RegWriteM, ResultSrcM, MemWriteM, ValidM
    );

    modport slave (
        input  ALUResultE, WriteDataE, PCPlus4E, RdE, Funct3E,
               RegWriteE, ResultSrcE, MemWriteE, ValidE,
        output ALUResultM, WriteDataM, PCPlus4M, RdM, Funct3M,
               RegWriteM, ResultSrcM, MemWriteM, ValidM
    );
endinterface

// File: rtl/preg_execute.sv
// Execute-to-Memory pipeline register with stall/flush/valid tracking and
// saturating retire/bubble counters for occupancy debug.
module preg_execute #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    preg_execute_if.slave        pipe,
    input  logic                 StallM,
    input  logic                 FlushM,
    input  logic                 CountClear,
    output logic [CNT_WIDTH-1:0] InstrCount,
    output logic [CNT_WIDTH-1:0] BubbleCount
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] alu;
        logic [DATA_WIDTH-1:0] wdata;
        logic [DATA_WIDTH-1:0] pc4;
        logic [4:0]            rd;
        logic [2:0]            funct3;
        logic                  regwrite;
        logic [1:0]            resultsrc;
        logic                  memwrite;
        logic                  valid;
    } stage_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    stage_t               stage_q, stage_d, load_s;
    logic [CNT_WIDTH-1:0] instr_q, instr_d;
    logic [CNT_WIDTH-1:0] bubble_q, bubble_d;

    // Write enables are qualified by ValidE so a bubble can never commit state downstream.
    always_comb begin
        load_s.alu       = pipe.ALUResultE;
        load_s.wdata     = pipe.WriteDataE;
        load_s.pc4       = pipe.PCPlus4E;
        load_s.rd        = pipe.RdE;
        load_s.funct3    = pipe.Funct3E;
        load_s.regwrite  = pipe.RegWriteE & pipe.ValidE;
        load_s.resultsrc = pipe.ResultSrcE;
        load_s.memwrite  = pipe.MemWriteE & pipe.ValidE;
        load_s.valid     = pipe.ValidE;
    end

    always_comb begin
        stage_d  = stage_q;
        instr_d  = instr_q;
        bubble_d = bubble_q;
        if (FlushM) begin
            stage_d  = '0;
            bubble_d = (bubble_q == '1) ? bubble_q : bubble_q + CNT_ONE;
        end else if (!StallM) begin
            stage_d = load_s;
            if (pipe.ValidE) begin
                instr_d = (instr_q == '1) ? instr_q : instr_q + CNT_ONE;
            end else begin
                bubble_d = (bubble_q == '1) ? bubble_q : bubble_q + CNT_ONE;
            end
        end
        // Clear only touches the counters and overrides any increment this cycle.
        if (CountClear) begin
            instr_d  = '0;
            bubble_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q  <= '0;
            instr_q  <= '0;
            bubble_q <= '0;
        end else begin
            stage_q  <= stage_d;
            instr_q  <= instr_d;
            bubble_q <= bubble_d;
        end
    end

    assign pipe.ALUResultM = stage_q.alu;
    assign pipe.WriteDataM = stage_q.wdata;
    assign pipe.PCPlus4M   = stage_q.pc4;
    assign pipe.RdM        = stage_q.rd;
    assign pipe.Funct3M    = stage_q.funct3;
    assign pipe.RegWriteM  = stage_q.regwrite;
    assign pipe.ResultSrcM = stage_q.resultsrc;
    assign pipe.MemWriteM  = stage_q.memwrite;
    assign pipe.ValidM     = stage_q.valid;
    assign InstrCount      = instr_q;
    assign BubbleCount     = bubble_q;

endmodule

// File: tb/tb_preg_execute.sv
// Directed bench for preg_execute: table-driven per-edge vectors plus hand-written
// sequences for counter saturation/clear and asynchronous reset during stall.
module tb_preg_execute;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        rw;
        logic [1:0]  rs;
        logic        mw;
        logic        v;
        logic        stall;
        logic        flush;
        logic        clr;
    } in_t;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        rw;
        logic [1:0]  rs;
        logic        mw;
        logic        v;
        logic [3:0]  ic;
        logic [3:0]  bc;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       StallM, FlushM, CountClear;
    logic [3:0] InstrCount, BubbleCount;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    preg_execute_if #(.DATA_WIDTH(32)) ifc ();

    preg_execute #(
        .DATA_WIDTH(32),
        .CNT_WIDTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pipe       (ifc.slave),
        .StallM     (StallM),
        .FlushM     (FlushM),
        .CountClear (CountClear),
        .InstrCount (InstrCount),
        .BubbleCount(BubbleCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_out(input string tag, input exp_t e);
        chk($sformatf("%s.ALUResultM", tag), ifc.ALUResultM, e.alu);
        chk($sformatf("%s.WriteDataM", tag), ifc.WriteDataM, e.wd);
        chk($sformatf("%s.PCPlus4M", tag),   ifc.PCPlus4M,   e.pc4);
        chk($sformatf("%s.RdM", tag),        32'(ifc.RdM),        32'(e.rd));
        chk($sformatf("%s.Funct3M", tag),    32'(ifc.Funct3M),    32'(e.f3));
        chk($sformatf("%s.RegWriteM", tag),  32'(ifc.RegWriteM),  32'(e.rw));
        chk($sformatf("%s.ResultSrcM", tag), 32'(ifc.ResultSrcM), 32'(e.rs));
        chk($sformatf("%s.MemWriteM", tag),  32'(ifc.MemWriteM),  32'(e.mw));
        chk($sformatf("%s.ValidM", tag),     32'(ifc.ValidM),     32'(e.v));
        chk($sformatf("%s.InstrCount", tag), 32'(InstrCount),     32'(e.ic));
        chk($sformatf("%s.BubbleCount", tag), 32'(BubbleCount),   32'(e.bc));
    endtask

    task automatic drive(input in_t i);
        ifc.ALUResultE = i.alu;
        ifc.WriteDataE = i.wd;
        ifc.PCPlus4E   = i.pc4;
        ifc.RdE        = i.rd;
        ifc.Funct3E    = i.f3;
        ifc.RegWriteE  = i.rw;
        ifc.ResultSrcE = i.rs;
        ifc.MemWriteE  = i.mw;
        ifc.ValidE     = i.v;
        StallM         = i.stall;
        FlushM         = i.flush;
        CountClear     = i.clr;
    endtask

    task automatic step(input in_t i);
        drive(i);
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[12];
    exp_t zero_e;
    exp_t e;
    in_t  in;

    initial begin
        zero_e = '0;

        // in:  alu, wd, pc4, rd, f3, rw, rs, mw, v, stall, flush, clr
        // exp: alu, wd, pc4, rd, f3, rw, rs, mw, v, ic, bc
        vecs[0]  = '{'{32'h1234, 32'h0, 32'h104, 5'd5, 3'd2, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
                     '{32'h1234, 32'h0, 32'h104, 5'd5, 3'd2, 1'b1, 2'b01, 1'b0, 1'b1, 4'd1, 4'd0}};
        vecs[1]  = '{'{32'hDEADBEEF, 32'h11, 32'h108, 5'd7, 3'd0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
                     '{32'h1234, 32'h0, 32'h104, 5'd5, 3'd2, 1'b1, 2'b01, 1'b0, 1'b1, 4'd1, 4'd0}};
        vecs[2]  = vecs[1];
        vecs[3]  = vecs[1];
        vecs[4]  = '{'{32'hDEADBEEF, 32'h11, 32'h108, 5'd7, 3'd0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
                     '{32'hDEADBEEF, 32'h11, 32'h108, 5'd7, 3'd0, 1'b1, 2'b00, 1'b0, 1'b1, 4'd2, 4'd0}};
        vecs[5]  = '{'{32'h55, 32'h66, 32'h10C, 5'd9, 3'd2, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0},
                     '{32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 4'd2, 4'd1}};
        vecs[6]  = '{'{32'h77, 32'hA5A5A5A5, 32'h200, 5'd3, 3'd1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
                     '{32'h77, 32'hA5A5A5A5, 32'h200, 5'd3, 3'd1, 1'b0, 2'b10, 1'b0, 1'b0, 4'd2, 4'd2}};
        vecs[7]  = '{'{32'h1000, 32'hCAFEF00D, 32'h20C, 5'd0, 3'd2, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
                     '{32'h1000, 32'hCAFEF00D, 32'h20C, 5'd0, 3'd2, 1'b0, 2'b00, 1'b1, 1'b1, 4'd3, 4'd2}};
        vecs[8]  = '{'{32'h42, 32'h0, 32'h210, 5'd0, 3'd0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
                     '{32'h42, 32'h0, 32'h210, 5'd0, 3'd0, 1'b1, 2'b00, 1'b0, 1'b1, 4'd4, 4'd2}};
        vecs[9]  = '{'{32'h99, 32'h99, 32'h99, 5'd1, 3'd1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1},
                     '{32'h42, 32'h0, 32'h210, 5'd0, 3'd0, 1'b1, 2'b00, 1'b0, 1'b1, 4'd0, 4'd0}};
        vecs[10] = '{'{32'h99, 32'h99, 32'h99, 5'd1, 3'd1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1},
                     '{32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 4'd0}};
        vecs[11] = '{'{32'h0, 32'h0, 32'h300, 5'd1, 3'd0, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
                     '{32'h0, 32'h0, 32'h300, 5'd1, 3'd0, 1'b1, 2'b10, 1'b0, 1'b1, 4'd1, 4'd0}};

        // Reset held across edges with every input nonzero.
        rst_n = 1'b0;
        drive('{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h1F, 3'h7, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
        repeat (3) @(posedge clk);
        #1;
        check_out("reset", zero_e);
        #2 rst_n = 1'b1;
        #1;
        check_out("release", zero_e);

        for (int k = 0; k < 12; k++) begin
            step(vecs[k].i);
            check_out($sformatf("vec%0d", k), vecs[k].e);
        end

        // Instruction counter saturation (InstrCount starts at 1 here).
        for (int k = 0; k < 20; k++) begin
            in = '{32'(k), 32'h0, 32'h0, 5'd2, 3'd0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            step(in);
        end
        e = '{32'd19, 32'h0, 32'h0, 5'd2, 3'd0, 1'b1, 2'b00, 1'b0, 1'b1, 4'd15, 4'd0};
        check_out("sat_instr", e);

        in = '{32'hAB, 32'h0, 32'h0, 5'd4, 3'd0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        step(in);
        e = '{32'hAB, 32'h0, 32'h0, 5'd4, 3'd0, 1'b1, 2'b00, 1'b0, 1'b1, 4'd0, 4'd0};
        check_out("clr_load", e);

        // Bubble counter saturation via flushes, then one invalid load at the ceiling.
        for (int k = 0; k < 20; k++) begin
            in = '{32'h1, 32'h1, 32'h1, 5'd1, 3'd1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
            step(in);
        end
        e = '{32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 4'd15};
        check_out("sat_bubble", e);
        in = '{32'h5, 32'h6, 32'h7, 5'd8, 3'd3, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        step(in);
        e = '{32'h5, 32'h6, 32'h7, 5'd8, 3'd3, 1'b0, 2'b01, 1'b0, 1'b0, 4'd0, 4'd15};
        check_out("sat_bubble_hold", e);

        // Asynchronous reset during a stall, then a stalled first edge after release.
        in = '{32'h5, 32'h6, 32'h7, 5'd8, 3'd3, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        step(in);
        check_out("pre_async", e);
        #2 rst_n = 1'b0;
        #1;
        check_out("async_rst", zero_e);
        #3 rst_n = 1'b1;
        step(in);
        check_out("post_rst_stall", zero_e);
        in.stall = 1'b0;
        step(in);
        e = '{32'h5, 32'h6, 32'h7, 5'd8, 3'd3, 1'b1, 2'b01, 1'b1, 1'b1, 4'd1, 4'd0};
        check_out("post_rst_load", e);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
